// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: access size encodings,
// controller states and the wait-state counter width.
package data_mem_ctrl_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  // Wide enough for LATENCY values 0..15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a little-endian XLEN-wide memory word.
// Store side: byte enables and replicated write data.
// Load side: lane select and sign/zero extension.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned NB   = XLEN / 8,
  localparam int unsigned LB   = $clog2(NB)
) (
  input  logic [LB-1:0]   lane,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [NB-1:0]   byte_en,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata
);

  int unsigned       nbytes;
  logic [XLEN-1:0]   shifted;
  logic              sign;

  // Access width in bytes, clamped to the word so illegal sizes stay in range
  always_comb begin
    case (size)
      MEM_B:   nbytes = 1;
      MEM_H:   nbytes = 2;
      MEM_W:   nbytes = 4;
      default: nbytes = 8;
    endcase
    if (nbytes > NB) nbytes = NB;
  end

  // Store: enable the addressed lanes and repeat the right-aligned data across the word
  always_comb begin
    byte_en   = '0;
    wdata_rep = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      byte_en[i]          = (i >= 32'(lane)) && (i < 32'(lane) + nbytes);
      wdata_rep[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end
  end

  // Load: shift the addressed lanes down, then extend above the access width
  always_comb begin
    shifted = rword >> {lane, 3'b000};
    sign    = shifted[8*nbytes-1] & ~is_unsigned;
    rdata   = '0;
    for (int unsigned b = 0; b < XLEN; b++) begin
      rdata[b] = (b < 8*nbytes) ? shifted[b] : sign;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller with valid/ready request and response channels,
// byte/half/word/double access, configurable wait states and error reporting.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned AW      = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned FW = AW - LB;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  // Storage is flattened; word i starts out holding the value i
  function automatic logic [DEPTH*XLEN-1:0] init_words();
    logic [DEPTH*XLEN-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DEPTH; i++) v[i*XLEN +: XLEN] = XLEN'(i);
    return v;
  endfunction

  logic [DEPTH*XLEN-1:0] mem = init_words();

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              ready_en;

  logic              lat_write, lat_unsigned;
  logic [AW-1:0]     lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [1:0]        lat_size;

  logic              cur_write, cur_unsigned;
  logic [AW-1:0]     cur_addr;
  logic [XLEN-1:0]   cur_wdata;
  logic [1:0]        cur_size;

  logic              accept, enter_resp;
  logic              misaligned, out_of_range, bad_size, err;
  logic [LB-1:0]     amask;
  logic [FW-1:0]     word_full;
  logic [IW-1:0]     word_idx;
  logic [XLEN-1:0]   rword, wdata_rep, load_data;
  logic [NB-1:0]     byte_en;

  // With LATENCY = 0 the access completes on the acceptance edge, so while idle
  // the live request is used; otherwise the latched copy is.
  assign cur_write    = (state == IDLE) ? req_write    : lat_write;
  assign cur_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
  assign cur_addr     = (state == IDLE) ? req_addr     : lat_addr;
  assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
  assign cur_size     = (state == IDLE) ? req_size     : lat_size;

  // Address decode and error classification for the current access
  always_comb begin
    amask        = LB'((4'd1 << cur_size) - 4'd1);
    misaligned   = |(cur_addr[LB-1:0] & amask);
    word_full    = cur_addr[AW-1:LB];
    out_of_range = (word_full >= FW'(DEPTH));
    bad_size     = (cur_size == MEM_D) && (NB < 8);
    err          = misaligned || out_of_range || bad_size;
    word_idx     = cur_addr[LB +: IW];
    rword        = mem[32'(word_idx)*XLEN +: XLEN];
  end

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .lane       (cur_addr[LB-1:0]),
    .size       (cur_size),
    .is_unsigned(cur_unsigned),
    .wdata      (cur_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_rep  (wdata_rep),
    .rdata      (load_data)
  );

  // State, wait counter, request latch and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ready_en     <= 1'b0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ready_en <= 1'b1;
      if (accept) begin
        lat_write    <= req_write;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
        lat_size     <= req_size;
      end
      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= (err || cur_write) ? '0 : load_data;
      end
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs and access strobes decoded from the state
  always_comb begin
    req_ready  = (state == IDLE) && ready_en;
    resp_valid = (state == RESP);
    accept     = req_valid && req_ready;
    enter_resp = ((state == WAIT) && (cnt == CNT_W'(1))) ||
                 ((state == IDLE) && accept && (LATENCY == 0));
  end

  // Store commit on the edge that enters RESP; errored stores write nothing
  always_ff @(posedge clk) begin
    if (enter_resp && cur_write && !err) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[32'(word_idx)*XLEN + 8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: scoreboard of expected responses
// produced by a byte-array reference model.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 128;
  localparam int unsigned AW      = 32;
  localparam int unsigned LATENCY = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic [1:0]      req_size = '0;
  logic            req_unsigned = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [7:0]  mbytes [DEPTH*4];

  // Reference model: little-endian byte array, updated by stores at issue time
  function automatic exp_t model_access(input logic w, input logic [31:0] addr,
                                        input logic [31:0] wd, input logic [1:0] size,
                                        input logic uns);
    exp_t r;
    int unsigned nb;
    logic [31:0] v;
    nb = 1 << size;
    r  = '0;
    if (size == 2'd3 || (addr % nb) != 0 || (addr / 4) >= DEPTH) begin
      r.err = 1'b1;
      return r;
    end
    if (w) begin
      for (int unsigned k = 0; k < nb; k++) mbytes[addr + k] = wd[8*k +: 8];
      return r;
    end
    v = '0;
    for (int unsigned k = 0; k < nb; k++) v[8*k +: 8] = mbytes[addr + k];
    if (!uns && nb < 4 && v[8*nb-1])
      for (int unsigned b = 8*nb; b < 32; b++) v[b] = 1'b1;
    r.rdata = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for acceptance, then scramble the idle inputs
  task automatic send(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] size, input logic uns, input bit use_model);
    int n;
    req_write = w; req_addr = addr; req_wdata = wd; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    if (use_model) sb.push_back(model_access(w, addr, wd, size, uns));
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    if (!req_ready) begin
      n_checks++; n_fails++;
      $display("FAIL send_ready: req_ready=%b, required 1 within 50 cycles", req_ready);
    end
    step();
    req_valid    = 1'b0;
    req_write    = 1'($urandom_range(0, 1));
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_resp(output bit ok);
    int n;
    n = 0;
    while (!resp_valid && n < 50) begin step(); n++; end
    ok = resp_valid;
    if (!ok) begin
      n_checks++; n_fails++;
      $display("FAIL resp_timeout: resp_valid=%b, required 1 within 50 cycles", resp_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release_ready: req_ready=%b, required 0 before first edge", req_ready);
    end
    step();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_first_edge_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    send(1'b0, 32'h0C, '0, MEM_W, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (req_ready !== 1'b0 || resp_valid !== (c == 3)) begin
        n_fails++;
        $display("FAIL latency_cycle%0d: ready=%b valid=%b, required ready=0 valid=%b",
                 c, req_ready, resp_valid, (c == 3));
      end
      if (c < 3) step();
    end
    e = sb.pop_front();
    n_checks++;
    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
      n_fails++;
      $display("FAIL latency_data: rdata=%h err=%b, required rdata=%h err=%b",
               resp_rdata, resp_err, e.rdata, e.err);
    end
    step();
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL latency_return_idle: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_store_loads();
    logic [31:0] addrs [6] = '{32'h10, 32'h13, 32'h13, 32'h11, 32'h12, 32'h10};
    logic [1:0]  sizes [6] = '{MEM_W, MEM_B, MEM_B, MEM_B, MEM_H, MEM_H};
    logic        unss  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit ok;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      send(i == 0, addrs[i], 32'h80FF1234, sizes[i], unss[i], 1'b1);
      wait_resp(ok);
      e = sb.pop_front();
      if (ok) begin
        n_checks++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_fails++;
          $display("FAIL store_load[%0d] addr=%h: rdata=%h err=%b, required rdata=%h err=%b",
                   i, addrs[i], resp_rdata, resp_err, e.rdata, e.err);
        end
      end
      step();
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] addrs [4] = '{32'h21, 32'h20, 32'h1C, 32'h24};
    logic [1:0]  sizes [4] = '{MEM_B, MEM_W, MEM_W, MEM_W};
    bit ok;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send(i == 0, addrs[i], 32'h000000AB, sizes[i], 1'b0, 1'b1);
      wait_resp(ok);
      e = sb.pop_front();
      if (ok) begin
        n_checks++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_fails++;
          $display("FAIL byte_store[%0d] addr=%h: rdata=%h err=%b, required rdata=%h err=%b",
                   i, addrs[i], resp_rdata, resp_err, e.rdata, e.err);
        end
      end
      step();
    end
  endtask

  task automatic test_errors();
    logic        ws    [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] addrs [7] = '{32'h11, 32'h202, 32'h0, 32'h200, 32'h08, 32'h1FC, 32'h1FF};
    logic [1:0]  sizes [7] = '{MEM_H, MEM_W, MEM_W, MEM_W, MEM_D, MEM_W, MEM_B};
    bit ok;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      send(ws[i], addrs[i], 32'hDEADBEEF, sizes[i], 1'b0, 1'b1);
      wait_resp(ok);
      e = sb.pop_front();
      if (ok) begin
        n_checks++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_fails++;
          $display("FAIL error_case[%0d] addr=%h size=%0d: rdata=%h err=%b, required rdata=%h err=%b",
                   i, addrs[i], sizes[i], resp_rdata, resp_err, e.rdata, e.err);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_t e;
    resp_ready = 1'b0;
    send(1'b0, 32'h40, '0, MEM_W, 1'b0, 1'b1);
    wait_resp(ok);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== e.rdata || resp_err !== e.err) begin
        n_fails++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b rdata=%h err=%b, required 1 0 %h %b",
                 c, resp_valid, req_ready, resp_rdata, resp_err, e.rdata, e.err);
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_t e;
    send(1'b1, 32'h04, 32'h55, MEM_W, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_outputs: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (3) step();
    rst = 1'b1;
    send(1'b0, 32'h04, '0, MEM_W, 1'b0, 1'b1);
    wait_resp(ok);
    e = sb.pop_front();
    if (ok) begin
      n_checks++;
      if (resp_rdata !== e.rdata || resp_err !== e.err) begin
        n_fails++;
        $display("FAIL reset_mid_discard: rdata=%h err=%b, required rdata=%h err=%b",
                 resp_rdata, resp_err, e.rdata, e.err);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_t e;
    logic        w, uns;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      w    = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 64)) & ~(($urandom_range(0, 3) == 0) ? 32'h0 : 32'h3);
      if (i % 10 == 9) addr = 32'h1F8 + 32'($urandom_range(0, 15));
      send(w, addr, $urandom, size, uns, 1'b1);
      wait_resp(ok);
      e = sb.pop_front();
      if (ok) begin
        n_checks++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_fails++;
          $display("FAIL random[%0d] w=%b addr=%h size=%0d uns=%b: rdata=%h err=%b, required rdata=%h err=%b",
                   i, w, addr, size, uns, resp_rdata, resp_err, e.rdata, e.err);
        end
      end
      step();
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < DEPTH*4; i++) begin
      logic [31:0] wv;
      wv = i / 4;
      mbytes[i] = wv[8*(i % 4) +: 8];
    end
    test_reset();
    test_latency();
    test_store_loads();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
